// File: rtl/platform_button_debounce.sv
// Push-button debouncer for a platform PIO input.
// The raw pin is synchronised, then a four-state FSM accepts a level change
// only after DEBOUNCE_CYCLES consecutive qualifying tick samples. It produces
// a registered debounced level and one-cycle press/release strobes.
module platform_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  input  logic tick,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse
);

  // Pin level seen while the button is not pressed.
  localparam logic PIN_IDLE = ACTIVE_LOW;

  // Final counter value; reaching it on a tick completes the debounce.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_e;

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed;
  logic             cnt_done;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Two-flop synchroniser; reset parks it at the idle pin level so no false press is seen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= button_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed  = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign cnt_done = (cnt_q == CNT_LAST);

  // State and debounce counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RELEASED;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the counter only advances on tick and stops at CNT_LAST, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (pressed) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_RELEASED;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = ST_RELEASED;
          cnt_d   = {CNT_W{1'b0}};
        end else if (tick) begin
          if (cnt_done) begin
            state_d = ST_PRESSED;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = cnt_q;
        end
      end
      ST_PRESSED: begin
        if (!pressed) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_PRESSED;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed) begin
          state_d = ST_PRESSED;
          cnt_d   = {CNT_W{1'b0}};
        end else if (tick) begin
          if (cnt_done) begin
            state_d = ST_RELEASED;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state, so the registered level changes on the same edge as the state.
  always_comb begin
    level_d   = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_d)
      ST_PRESSED, ST_RELEASE_WAIT: level_d = 1'b1;
      ST_RELEASED, ST_PRESS_WAIT:  level_d = 1'b0;
      default:                     level_d = 1'b0;
    endcase
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Output registers; reset drops the level silently, without a release strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_platform_button_debounce.sv
// Self-checking bench for platform_button_debounce (DEBOUNCE_CYCLES=4, active-low pin).
module tb_platform_button_debounce;

  localparam int N  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic button_raw;
  logic tick;
  logic button_level;
  logic press_pulse;
  logic release_pulse;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state: pin history, accepted level, qualifying-tick run.
  logic m_s1 = 1'b1;
  logic m_s2 = 1'b1;
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_rel = 1'b0;
  int   m_run = -1;

  always #5 clk = ~clk;

  platform_button_debounce #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W(CW),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .button_raw(button_raw),
    .tick(tick),
    .button_level(button_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  // Apply inputs, advance one clock edge, update the behavioural model, settle.
  task automatic step(input logic rn, input logic pin, input logic tk);
    logic old;
    logic p;
    reset_n = rn;
    button_raw = pin;
    tick = tk;
    @(posedge clk);
    if (!rn) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_run = -1;
      m_press = 1'b0; m_rel = 1'b0;
    end else begin
      old = m_level;
      p = ~m_s2;
      // The accepted level flips on the N-th tick after disagreement was first seen.
      if (p == m_level) m_run = -1;
      else if (m_run < 0) m_run = 0;
      else if (tk) begin
        m_run = m_run + 1;
        if (m_run == N) begin
          m_level = ~m_level;
          m_run = -1;
        end
      end
      m_s2 = m_s1;
      m_s1 = pin;
      m_press = m_level & ~old;
      m_rel = ~m_level & old;
    end
    #1;
  endtask

  // Monitor: pulses exclusive, non-consecutive, alternating; level moves only with a pulse.
  logic rst_at_edge = 1'b0;
  logic mon_prev_level = 1'b0;
  logic mon_prev_pulse = 1'b0;
  logic mon_expect_press = 1'b1;
  always @(posedge clk) rst_at_edge <= reset_n;
  always @(negedge clk) begin
    logic [3:0] viol;
    if (!rst_at_edge) begin
      mon_prev_level = 1'b0;
      mon_prev_pulse = 1'b0;
      mon_expect_press = 1'b1;
    end else begin
      viol[3] = press_pulse & release_pulse;
      viol[2] = (press_pulse | release_pulse) & mon_prev_pulse;
      viol[1] = (button_level != mon_prev_level) != (press_pulse | release_pulse);
      viol[0] = (press_pulse & ~mon_expect_press) | (release_pulse & mon_expect_press);
      vec_cnt++;
      if (viol !== 4'b0000) begin
        err_cnt++;
        $display("FAIL monitor t=%0t: violation flags %b (want 0000) lvl=%b p=%b r=%b",
                 $time, viol, button_level, press_pulse, release_pulse);
      end
      mon_prev_level = button_level;
      mon_prev_pulse = press_pulse | release_pulse;
      if (press_pulse) mon_expect_press = 1'b0;
      if (release_pulse) mon_expect_press = 1'b1;
    end
  end

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1);
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== 3'b000) begin
        err_cnt++;
        $display("FAIL reset_hold %0d: got %b want 000", k, {button_level, press_pulse, release_pulse});
      end
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b1);
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== 3'b000) begin
        err_cnt++;
        $display("FAIL reset_idle %0d: got %b want 000", k, {button_level, press_pulse, release_pulse});
      end
    end
  endtask

  task automatic test_press_release();
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 1'b1);
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== {(k >= 7), (k == 7), 1'b0}) begin
        err_cnt++;
        $display("FAIL press edge %0d: got %b want %b", k,
                 {button_level, press_pulse, release_pulse}, {(k >= 7), (k == 7), 1'b0});
      end
    end
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b1, 1'b1);
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== {(k < 7), 1'b0, (k == 7)}) begin
        err_cnt++;
        $display("FAIL release edge %0d: got %b want %b", k,
                 {button_level, press_pulse, release_pulse}, {(k < 7), 1'b0, (k == 7)});
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 16; k++) begin
      step(1'b1, pat[k], 1'b1);
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== 3'b000 ||
          {m_level, m_press, m_rel} !== 3'b000) begin
        err_cnt++;
        $display("FAIL bounce %0d: got %b want 000 (model %b)", k,
                 {button_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
      end
    end
  endtask

  task automatic test_slow_tick();
    int   nt;
    logic tk;
    logic exp_press;
    nt = 0;
    for (int k = 1; k <= 24; k++) begin
      tk = ((k % 3) == 0);
      step(1'b1, 1'b0, tk);
      // Edge 3 enters the wait state; ticks after that are the qualifying samples.
      exp_press = 1'b0;
      if (k > 3 && tk) begin
        nt++;
        exp_press = (nt == 4);
      end
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== {(nt >= 4), exp_press, 1'b0}) begin
        err_cnt++;
        $display("FAIL slow_tick edge %0d: got %b want %b", k,
                 {button_level, press_pulse, release_pulse}, {(nt >= 4), exp_press, 1'b0});
      end
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== {m_level, m_press, m_rel}) begin
        err_cnt++;
        $display("FAIL slow_tick_release %0d: got %b want %b", k,
                 {button_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
      end
    end
  endtask

  task automatic test_reset_while_pressed();
    for (int k = 1; k <= 9; k++) step(1'b1, 1'b0, 1'b1);
    vec_cnt++;
    if (button_level !== 1'b1) begin
      err_cnt++;
      $display("FAIL rwp_pressed: got %b want 1", button_level);
    end
    step(1'b0, 1'b0, 1'b1);
    vec_cnt++;
    if ({button_level, press_pulse, release_pulse} !== 3'b000) begin
      err_cnt++;
      $display("FAIL rwp_in_reset: got %b want 000", {button_level, press_pulse, release_pulse});
    end
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 1'b1);
      vec_cnt++;
      if ({button_level, press_pulse, release_pulse} !== {(k >= 7), (k == 7), 1'b0}) begin
        err_cnt++;
        $display("FAIL rwp_repress edge %0d: got %b want %b", k,
                 {button_level, press_pulse, release_pulse}, {(k >= 7), (k == 7), 1'b0});
      end
    end
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);
    vec_cnt++;
    if (button_level !== 1'b0) begin
      err_cnt++;
      $display("FAIL rwp_released: got %b want 0", button_level);
    end
  endtask

  task automatic test_random_bursts();
    logic tgt;
    logic pin;
    logic tk;
    logic rn;
    int   blen;
    int   slen;
    for (int seg = 0; seg < 150; seg++) begin
      tgt  = 1'($urandom_range(1, 0));
      blen = $urandom_range(6, 0);
      slen = $urandom_range(14, 0);
      for (int k = 0; k < blen + slen; k++) begin
        pin = (k < blen) ? 1'($urandom_range(1, 0)) : tgt;
        tk  = ($urandom_range(4, 0) != 0);
        rn  = ($urandom_range(150, 0) != 0);
        step(rn, pin, tk);
        vec_cnt++;
        if ({button_level, press_pulse, release_pulse} !== {m_level, m_press, m_rel}) begin
          err_cnt++;
          $display("FAIL random seg %0d cyc %0d: got %b want %b", seg, k,
                   {button_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_slow_tick();
    test_reset_while_pressed();
    test_random_bursts();
    step(1'b1, 1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/platform_button_debounce.md
PLATFORM_BUTTON_DEBOUNCE -- requirements
Module: platform_button_debounce

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive qualifying samples required to accept a level change; legal range 2..2^CNT_W.
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning the debounce counter width.
REQ-003 The module SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port button_raw, input, 1 bit: the asynchronous push-button pin.
REQ-007 The module SHALL have port tick, input, 1 bit: sample enable; the debounce counter advances only on cycles with tick=1.
REQ-008 The module SHALL have port button_level, output, 1 bit: debounced pressed level (1 = pressed), driven directly to the PIO in_port.
REQ-009 The module SHALL have port press_pulse, output, 1 bit: one-cycle strobe on an accepted press.
REQ-010 The module SHALL have port release_pulse, output, 1 bit: one-cycle strobe on an accepted release.

Function
REQ-011 button_raw SHALL pass through a 2-flop synchronizer (sync1 then sync2) before any other use.
REQ-012 Internal pressed SHALL be ~sync2 when ACTIVE_LOW=1, and sync2 otherwise.
REQ-013 The FSM SHALL have exactly four states: RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-014 In RELEASED with pressed=1, the FSM SHALL go to PRESS_WAIT and clear the counter to 0; otherwise it SHALL stay in RELEASED.
REQ-015 In PRESS_WAIT with pressed=0, the FSM SHALL return to RELEASED, clear the counter and emit no pulse, regardless of tick.
REQ-016 In PRESS_WAIT with pressed=1 and tick=1, the FSM SHALL enter PRESSED if counter == DEBOUNCE_CYCLES-1, else increment the counter; with tick=0 the counter SHALL hold.
REQ-017 PRESSED and RELEASE_WAIT SHALL mirror REQ-014..016 with pressed inverted; RELEASE_WAIT completion SHALL enter RELEASED.
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 button_level SHALL be a register: 1 in PRESSED and RELEASE_WAIT, 0 in RELEASED and PRESS_WAIT.
REQ-020 press_pulse SHALL be registered and high for exactly the first cycle in which button_level=1; release_pulse SHALL behave likewise for the first cycle in which button_level=0 after a press.
REQ-021 With tick held at 1, after a clean press whose pressed value is first visible at sync2 after edge E, button_level and press_pulse SHALL rise after edge E+1+DEBOUNCE_CYCLES.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle, and SHALL never be high in consecutive cycles.
REQ-023 A bounce shorter than DEBOUNCE_CYCLES qualifying samples SHALL produce no change on any output.

Reset
REQ-024 While reset_n=0 at a clk edge, the module SHALL load sync1 and sync2 with the released pin level (ACTIVE_LOW ? 1 : 0), put the FSM in RELEASED, clear the counter, and drive button_level, press_pulse and release_pulse to 0.
REQ-025 Reset asserted mid-debounce or while PRESSED SHALL abort without a pulse.
REQ-026 After reset release, a button still held SHALL require a full debounce and SHALL then produce one press_pulse.
REQ-027 reset_n SHALL have no asynchronous effect.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, tick=1 unless stated)
REQ-028 Scenario: reset with button_raw=1, release -> all outputs 0 and held at 0 for 20 cycles.
REQ-029 Scenario: button_raw driven 0 and held -> button_level=1 and press_pulse=1 for one cycle, 7 edges after the pin change (2 sync + 1 + 4); raise button_raw -> release_pulse 7 edges later, and button_level=0 in that same cycle.
REQ-030 Scenario: button_raw pattern 0,0,0,1,0,0,0,1 (cycles of pin value) -> no output change and no pulse.
REQ-031 Scenario: tick=1 on every third cycle only, button held -> press accepted after exactly 4 tick cycles in PRESS_WAIT.
REQ-032 Scenario: reset_n pulsed low for 1 cycle while PRESSED with button held -> button_level=0 immediately after reset, then a single press_pulse 7 edges after reset release.
REQ-033 Scenario: random bounce bursts, checked by an assertion monitor -> press and release pulses strictly alternate, and button_level only toggles coincident with a pulse.
